// File: rtl/ram_dp_be_init.sv
// Simple dual-port RAM: byte-lane writes, 1- or 2-clock read latency,
// selectable collision behaviour, post-reset clear sweep and bad-address flag.
module ram_dp_be_init #(
  parameter int                DEPTH          = 256,
  parameter int                DWIDTH         = 8,
  parameter int                RD_LATENCY     = 1,
  parameter int                COLLISION_MODE = 0,
  parameter logic [DWIDTH-1:0] INIT_VAL       = '0,
  localparam int               AWIDTH         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int               BEW            = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enbl,
  input  logic [BEW-1:0]    wr_byte_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_enbl,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              addr_err
);

  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state;
  logic [AWIDTH-1:0]      ptr;
  logic                   run, wr_oor, rd_oor, wr_ok, rd_ok;
  logic [RD_LATENCY:1]    vld_pipe;
  logic [BEW-1:0][7:0]    lane_q;

  assign run   = (state == S_RUN);
  assign wr_ok = run && wr_enbl && !wr_oor;
  assign rd_ok = run && rd_enbl && !rd_oor;

  // Out-of-range addresses only exist when DEPTH leaves part of the address space unused.
  if (DEPTH == (1 << AWIDTH)) begin : g_pow2
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
  end else begin : g_npow2
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
    assign wr_oor = ({1'b0, wr_addr} >= DEPTH_W);
    assign rd_oor = ({1'b0, rd_addr} >= DEPTH_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          if (ptr == LAST) begin
            state     <= S_RUN;
            init_busy <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      addr_err <= 1'b0;
    end else begin
      vld_pipe[1] <= rd_ok;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      addr_err <= run && ((wr_enbl && wr_oor) || (rd_enbl && rd_oor));
    end
  end

  // One storage column per byte lane; the clear sweep shares the write port.
  for (genvar g = 0; g < BEW; g++) begin : g_lane
    logic [7:0]        mem [DEPTH];
    logic [7:0]        q;
    logic              we;
    logic [AWIDTH-1:0] wa;
    logic [7:0]        wd;

    assign we = run ? (wr_ok && wr_byte_en[g]) : 1'b1;
    assign wa = run ? wr_addr : ptr;
    assign wd = run ? wr_data[8*g +: 8] : INIT_VAL[8*g +: 8];

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        q <= '0;
      else if (rd_ok)
        q <= (COLLISION_MODE == 1 && wr_ok && wr_byte_en[g] && wr_addr == rd_addr)
             ? wr_data[8*g +: 8] : mem[rd_addr];
    end

    assign lane_q[g] = q;
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data = lane_q;
  end else begin : g_lat2
    always_ff @(posedge clk or posedge rst) begin
      if (rst)              rd_data <= '0;
      else if (vld_pipe[1]) rd_data <= lane_q;
    end
  end

  assign rd_valid = vld_pipe[RD_LATENCY];

endmodule

// File: tb/tb_ram_dp_be_init.sv
// Bench for ram_dp_be_init: two configurations (read-first/latency 1 with a
// non-power-of-2 depth, write-first/latency 2) checked against shadow memories.
module tb_ram_dp_be_init;

  localparam int          A_DEPTH = 200;
  localparam int          A_LAT   = 1;
  localparam logic [31:0] A_INIT  = 32'h0BAD_F00D;
  localparam int          B_DEPTH = 16;
  localparam int          B_LAT   = 2;
  localparam logic [15:0] B_INIT  = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_wr_enbl, a_rd_enbl, a_rd_valid, a_init_busy, a_addr_err;
  logic [3:0]  a_wr_byte_en;
  logic [7:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;

  logic        b_wr_enbl, b_rd_enbl, b_rd_valid, b_init_busy, b_addr_err;
  logic [1:0]  b_wr_byte_en;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_rd_data;

  ram_dp_be_init #(.DEPTH(A_DEPTH), .DWIDTH(32), .RD_LATENCY(A_LAT),
                   .COLLISION_MODE(0), .INIT_VAL(A_INIT)) dut_a (
    .clk(clk), .rst(rst), .wr_enbl(a_wr_enbl), .wr_byte_en(a_wr_byte_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .rd_enbl(a_rd_enbl), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .init_busy(a_init_busy), .addr_err(a_addr_err));

  ram_dp_be_init #(.DEPTH(B_DEPTH), .DWIDTH(16), .RD_LATENCY(B_LAT),
                   .COLLISION_MODE(1), .INIT_VAL(B_INIT)) dut_b (
    .clk(clk), .rst(rst), .wr_enbl(b_wr_enbl), .wr_byte_en(b_wr_byte_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rd_enbl(b_rd_enbl), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .init_busy(b_init_busy), .addr_err(b_addr_err));

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] ma [A_DEPTH];
  logic [15:0] mb [B_DEPTH];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  task automatic idle();
    a_wr_enbl = 0; a_wr_byte_en = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_enbl = 0; a_rd_addr = '0;
    b_wr_enbl = 0; b_wr_byte_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_enbl = 0; b_rd_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < A_DEPTH; i++) ma[i] = A_INIT;
    for (int i = 0; i < B_DEPTH; i++) mb[i] = B_INIT;
    qa.delete();
    qb.delete();
  endtask

  // Read-first model: expected word is captured before the write lands.
  task automatic drive_a(input logic we, input logic [3:0] be, input int wa, input logic [31:0] wd,
                         input logic re, input int ra);
    exp_t e;
    a_wr_enbl = we; a_wr_byte_en = be; a_wr_addr = 8'(wa); a_wr_data = wd;
    a_rd_enbl = re; a_rd_addr = 8'(ra);
    if (re && ra < A_DEPTH) begin
      e.data = ma[ra]; e.due = cyc + A_LAT; qa.push_back(e);
    end
    if (we && wa < A_DEPTH)
      for (int l = 0; l < 4; l++) if (be[l]) ma[wa][8*l +: 8] = wd[8*l +: 8];
  endtask

  // Write-first model: enabled lanes of a colliding write replace the old bytes.
  task automatic drive_b(input logic we, input logic [1:0] be, input int wa, input logic [15:0] wd,
                         input logic re, input int ra);
    exp_t        e;
    logic [15:0] w;
    b_wr_enbl = we; b_wr_byte_en = be; b_wr_addr = 4'(wa); b_wr_data = wd;
    b_rd_enbl = re; b_rd_addr = 4'(ra);
    if (re && ra < B_DEPTH) begin
      w = mb[ra];
      if (we && wa == ra)
        for (int l = 0; l < 2; l++) if (be[l]) w[8*l +: 8] = wd[8*l +: 8];
      e.data = {16'h0, w}; e.due = cyc + B_LAT; qb.push_back(e);
    end
    if (we && wa < B_DEPTH)
      for (int l = 0; l < 2; l++) if (be[l]) mb[wa][8*l +: 8] = wd[8*l +: 8];
  endtask

  // One clock; scoreboard pops on rd_valid and flags missing or late reads.
  task automatic clk_step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (a_rd_valid) begin
      total++;
      if (qa.size() == 0) begin
        bad++; $display("FAIL a_stray_valid got=%h cyc=%0d", a_rd_data, cyc);
      end else begin
        e = qa.pop_front();
        if (a_rd_data !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL a_read got=%h@%0d want=%h@%0d", a_rd_data, cyc, e.data, e.due);
        end
      end
    end
    if (qa.size() != 0 && qa[0].due < cyc) begin
      total++; bad++;
      $display("FAIL a_missing_valid want=%h@%0d now=%0d", qa[0].data, qa[0].due, cyc);
      void'(qa.pop_front());
    end
    if (b_rd_valid) begin
      total++;
      if (qb.size() == 0) begin
        bad++; $display("FAIL b_stray_valid got=%h cyc=%0d", b_rd_data, cyc);
      end else begin
        e = qb.pop_front();
        if ({16'h0, b_rd_data} !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL b_read got=%h@%0d want=%h@%0d", b_rd_data, cyc, e.data[15:0], e.due);
        end
      end
    end
    if (qb.size() != 0 && qb[0].due < cyc) begin
      total++; bad++;
      $display("FAIL b_missing_valid want=%h@%0d now=%0d", qb[0].data[15:0], qb[0].due, cyc);
      void'(qb.pop_front());
    end
  endtask

  task automatic drain(input string name);
    idle();
    repeat (4) clk_step();
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++; $display("FAIL %s_drain left a=%0d b=%0d want 0", name, qa.size(), qb.size());
    end
  endtask

  // Counts clocks of init_busy after release while hammering the ports with junk.
  task automatic sweep_count(input string name);
    int an = 0, bn = 0;
    logic err_seen = 0;
    for (int k = 1; k <= 1000 && (an == 0 || bn == 0); k++) begin
      idle();
      if (k <= 50) begin
        a_wr_enbl = 1; a_wr_byte_en = 4'hF; a_wr_addr = 8'd7; a_wr_data = 32'hFFFF_FFFF;
        a_rd_enbl = 1; a_rd_addr = (k % 2 == 1) ? 8'd250 : 8'd7;
      end
      if (k <= B_DEPTH) begin
        b_wr_enbl = 1; b_wr_byte_en = 2'b11; b_wr_addr = 4'd3; b_wr_data = 16'h0000;
        b_rd_enbl = 1; b_rd_addr = 4'd3;
      end
      clk_step();
      if (a_addr_err || b_addr_err) err_seen = 1;
      if (!a_init_busy && an == 0) an = k;
      if (!b_init_busy && bn == 0) bn = k;
    end
    idle();
    total++;
    if (an != A_DEPTH) begin bad++; $display("FAIL %s_a_busy_clocks got=%0d want=%0d", name, an, A_DEPTH); end
    total++;
    if (bn != B_DEPTH) begin bad++; $display("FAIL %s_b_busy_clocks got=%0d want=%0d", name, bn, B_DEPTH); end
    total++;
    if (err_seen !== 1'b0) begin bad++; $display("FAIL %s_addr_err_in_init got=1 want=0", name); end
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({a_rd_data, a_rd_valid, a_addr_err, a_init_busy} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_a got data=%h v=%b e=%b busy=%b want 0/0/0/1",
                      a_rd_data, a_rd_valid, a_addr_err, a_init_busy);
    end
    total++;
    if ({b_rd_data, b_rd_valid, b_addr_err, b_init_busy} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_b got data=%h v=%b e=%b busy=%b want 0/0/0/1",
                      b_rd_data, b_rd_valid, b_addr_err, b_init_busy);
    end
    model_reset();
    rst = 0;
    sweep_count("reset");
  endtask

  task automatic test_init_read();
    for (int i = 0; i < A_DEPTH; i++) begin
      idle();
      drive_a(0, 4'h0, 0, 32'h0, 1, i);
      if (i < B_DEPTH) drive_b(0, 2'b00, 0, 16'h0, 1, i);
      clk_step();
    end
    drain("init_read");
  endtask

  task automatic test_byte_en();
    idle(); drive_a(1, 4'hF, 5, 32'hAABB_CCDD, 0, 0); drive_b(1, 2'b11, 2, 16'h1234, 0, 0); clk_step();
    idle(); drive_a(1, 4'b0101, 5, 32'h1122_3344, 0, 0); drive_b(1, 2'b10, 2, 16'hABCD, 0, 0); clk_step();
    idle(); drive_a(1, 4'b0000, 5, 32'hFFFF_FFFF, 0, 0); clk_step();
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 5); drive_b(0, 2'b00, 0, 16'h0, 1, 2); clk_step();
    drain("byte_en");
    total++;
    if (a_rd_data !== 32'hAA22_CC44) begin bad++; $display("FAIL byte_en_a_hold got=%h want=aa22cc44", a_rd_data); end
    total++;
    if (b_rd_data !== 16'hAB34) begin bad++; $display("FAIL byte_en_b_hold got=%h want=ab34", b_rd_data); end
  endtask

  task automatic test_collision();
    idle(); drive_a(1, 4'hF, 9, 32'h0000_003C, 0, 0); drive_b(1, 2'b11, 9, 16'h003C, 0, 0); clk_step();
    idle(); drive_a(1, 4'hF, 9, 32'h0000_00C3, 1, 9); drive_b(1, 2'b11, 9, 16'h00C3, 1, 9); clk_step();
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 9); drive_b(0, 2'b00, 0, 16'h0, 1, 9); clk_step();
    drain("collision");
    total++;
    if (a_rd_data !== 32'h0000_00C3) begin bad++; $display("FAIL collision_a_after got=%h want=000000c3", a_rd_data); end
    // Partial-lane collision on the write-first port: only lane 0 takes new data.
    idle(); drive_b(1, 2'b11, 9, 16'h3C3C, 0, 0); clk_step();
    idle(); drive_b(1, 2'b01, 9, 16'hC3C3, 1, 9); clk_step();
    idle(); drive_b(0, 2'b00, 0, 16'h0, 1, 9); clk_step();
    drain("collision_part");
    total++;
    if (b_rd_data !== 16'h3CC3) begin bad++; $display("FAIL collision_b_part got=%h want=3cc3", b_rd_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      idle(); drive_b(1, 2'b11, i, 16'(i * 16'h1111), 0, 0); clk_step();
    end
    for (int i = 1; i <= 3; i++) begin
      idle(); drive_b(0, 2'b00, 0, 16'h0, 1, i); clk_step();
    end
    drain("b2b");
    for (int n = 0; n < 300; n++) begin
      idle();
      drive_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, A_DEPTH - 1),
              $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, A_DEPTH - 1));
      drive_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, B_DEPTH - 1),
              16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, B_DEPTH - 1));
      clk_step();
    end
    drain("random");
  endtask

  task automatic test_addr_err();
    idle(); drive_a(1, 4'hF, 210, 32'hDEAD_BEEF, 0, 0); clk_step();
    total++;
    if (a_addr_err !== 1'b1) begin bad++; $display("FAIL addr_err_wr got=%b want=1", a_addr_err); end
    idle(); clk_step();
    total++;
    if (a_addr_err !== 1'b0) begin bad++; $display("FAIL addr_err_wr_pulse got=%b want=0", a_addr_err); end
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 250); clk_step();
    total++;
    if (a_addr_err !== 1'b1) begin bad++; $display("FAIL addr_err_rd got=%b want=1", a_addr_err); end
    idle(); drive_a(1, 4'hF, 201, 32'h5555_AAAA, 1, 255); clk_step();
    total++;
    if (a_addr_err !== 1'b1) begin bad++; $display("FAIL addr_err_both got=%b want=1", a_addr_err); end
    idle(); clk_step();
    total++;
    if (a_addr_err !== 1'b0) begin bad++; $display("FAIL addr_err_both_pulse got=%b want=0", a_addr_err); end
    idle(); drive_a(1, 4'hF, A_DEPTH - 1, 32'h1234_5678, 1, A_DEPTH - 1); clk_step();
    total++;
    if (a_addr_err !== 1'b0) begin bad++; $display("FAIL addr_err_last_addr got=%b want=0", a_addr_err); end
    for (int i = 0; i < 5; i++) begin
      idle(); drive_a(0, 4'h0, 0, 32'h0, 1, (i == 0) ? 82 : (i == 1) ? 73 : (i == 2) ? 10 : (i == 3) ? 199 : 0);
      clk_step();
    end
    drain("addr_err");
  endtask

  task automatic test_reset_midsweep();
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 5); drive_b(0, 2'b00, 0, 16'h0, 1, 5); clk_step();
    idle();
    rst = 1;
    #1;
    model_reset();
    total++;
    if ({a_rd_data, a_rd_valid, b_rd_valid, a_init_busy, b_init_busy} !== {32'h0, 4'b0011}) begin
      bad++; $display("FAIL midreset_async got a=%h va=%b vb=%b busy=%b%b want 0/0/0/11",
                      a_rd_data, a_rd_valid, b_rd_valid, a_init_busy, b_init_busy);
    end
    repeat (3) clk_step();
    rst = 0;
    repeat (100) clk_step();
    total++;
    if (a_init_busy !== 1'b1) begin bad++; $display("FAIL midsweep_busy got=%b want=1", a_init_busy); end
    rst = 1;
    clk_step();
    rst = 0;
    sweep_count("restart");
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 7);   drive_b(0, 2'b00, 0, 16'h0, 1, 3); clk_step();
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 0);   drive_b(0, 2'b00, 0, 16'h0, 1, 9); clk_step();
    idle(); drive_a(0, 4'h0, 0, 32'h0, 1, 199); drive_b(0, 2'b00, 0, 16'h0, 1, 15); clk_step();
    drain("midsweep");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_init_read();
    test_byte_en();
    test_collision();
    test_back_to_back();
    test_addr_err();
    test_reset_midsweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
